batalha_naval_board: RTL and testbench
======================================

BATALHA_NAVAL_BOARD -- requirements
Module: batalha_naval_board

Interface
REQ-001 The block SHALL take parameter ROWS, default 7, meaning the number of board rows (LED matrix lines).
REQ-002 The block SHALL take parameter COLS, default 5, meaning the number of board columns (LED matrix columns).
REQ-003 The block SHALL take parameter MAX_SHOTS, default 35, meaning the attack budget before forced game over.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port clr, input, 1, the reset: asynchronous and active-high.
REQ-006 The block SHALL have port mode, input, 2, the game mode: 00 idle, 01 place, 10 attack, 11 reveal.
REQ-007 The block SHALL have port load_map, input, 1, a one-cycle pulse that captures ship_map.
REQ-008 The block SHALL have port ship_map, input, ROWS*COLS, the preset ship layout; bit r*COLS+c is cell (r,c).
REQ-009 The block SHALL have port fire, input, 1, a one-cycle debounced attack pulse.
REQ-010 The block SHALL have port row_sel, input, clog2(ROWS), the attack row coordinate.
REQ-011 The block SHALL have port col_sel, input, clog2(COLS), the attack column coordinate.
REQ-012 The block SHALL have port scan_tick, input, 1, the display column-advance strobe.
REQ-013 The block SHALL have port m_col, output, COLS, the one-hot active-high column drive.
REQ-014 The block SHALL have port m_line, output, ROWS, the active-low line drive.
REQ-015 The block SHALL have port rgb_output, output, 2, the last result: 00 none, 01 miss, 10 hit, 11 repeat/invalid.
REQ-016 The block SHALL have port hits, output, clog2(ROWS*COLS+1), the count of distinct hit cells.
REQ-017 The block SHALL have port shots, output, clog2(MAX_SHOTS+1), the count of accepted shots.
REQ-018 The block SHALL have port game_over, output, 1, asserted when the game has ended.

Function
REQ-019 FSM states SHALL be IDLE, ARMED, CHECK, OVER.
REQ-020 IDLE SHALL go to ARMED on load_map while mode=01: capture ship_map, clear the attack map, clear hits, clear shots, compute ships=popcount(ship_map).
REQ-021 ARMED SHALL go to CHECK on fire while mode=10; fire in any other state or mode SHALL be ignored.
REQ-022 A shot with row_sel>=ROWS or col_sel>=COLS SHALL set rgb_output=11, SHALL NOT change the attack map, shots or hits, and the FSM SHALL return to ARMED.
REQ-023 In CHECK, an already-attacked cell SHALL set rgb_output=11, leave shots unchanged, and return to ARMED.
REQ-024 In CHECK, a new cell SHALL set its attack bit, increment shots, set rgb_output=10 and increment hits if it is a ship cell, else set rgb_output=01; the result SHALL be visible exactly 2 clk edges after the fire edge.
REQ-025 The FSM SHALL leave CHECK for OVER when the updated hits equals ships (ships>0) or the updated shots equals MAX_SHOTS; otherwise it SHALL return to ARMED.
REQ-026 game_over SHALL equal (state==OVER); OVER SHALL be left only via load_map in mode 01, which goes to ARMED.
REQ-027 load_map with ships=0 SHALL capture the map but the FSM SHALL stay IDLE.
REQ-028 Counters SHALL never wrap; shots saturates at MAX_SHOTS.
REQ-029 Column scan counter SHALL advance on scan_tick and wrap COLS-1 to 0; m_col SHALL be the one-hot decode of the counter.
REQ-030 m_line bit r SHALL be low when the displayed cell is lit: mode 00 none lit; 01 ship cells; 10 attacked cells that are hits, with misses blinking at the scan-counter wrap rate; 11 ship OR attacked.
REQ-031 fire and load_map in the same cycle: load_map SHALL win.

Reset
REQ-032 While clr=1: state=IDLE, ship/attack maps=0, hits=0, shots=0, rgb_output=00, game_over=0, scan counter=0, m_col=one-hot bit 0, m_line=all ones.
REQ-033 clr asserted mid-CHECK SHALL abort the shot with no partial update visible after release.

Structure
REQ-034 Package batalha_naval_pkg SHALL hold the FSM state enum, the mode encodings and the rgb result encodings.
REQ-035 The scan/display logic SHALL be one sub-module, board_scan_mux, parametrised by ROWS and COLS.

Verification
REQ-036 Reset, then mode=01, load_map with ship_map bit 0 only -> state ARMED, ships=1, m_line[0]=0 when m_col=00001.
REQ-037 Mode=10, fire at (0,0) -> rgb_output=10 after 2 edges, hits=1, shots=1, game_over=1.
REQ-038 Two-ship map, fire at (3,2) twice -> first gives 01 and shots=1; second gives 11 and shots stays 1.
REQ-039 fire with row_sel=7 (ROWS=7) -> rgb_output=11, shots=0, attack map unchanged.
REQ-040 MAX_SHOTS=3, three distinct misses -> game_over=1 and a fourth fire is ignored.
REQ-041 Five scan_ticks with COLS=5 -> m_col sequence 00010,00100,01000,10000,00001; clr mid-CHECK -> all REQ-032 values.

Source files
------------

// File: rtl/batalha_naval_pkg.sv
// ---------------------------------------------------------------------------
// batalha_naval_pkg
// Shared types and encodings for the battleship board controller.
//   state_t      : FSM states of batalha_naval_board
//   MODE_*       : encodings of the 2-bit mode input
//   RGB_*        : encodings of the 2-bit rgb_output result
// ---------------------------------------------------------------------------
package batalha_naval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      CHECK = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_IDLE   = 2'b00;
   localparam logic [1:0] MODE_PLACE  = 2'b01;
   localparam logic [1:0] MODE_ATTACK = 2'b10;
   localparam logic [1:0] MODE_REVEAL = 2'b11;

   localparam logic [1:0] RGB_NONE   = 2'b00;
   localparam logic [1:0] RGB_MISS   = 2'b01;
   localparam logic [1:0] RGB_HIT    = 2'b10;
   localparam logic [1:0] RGB_REPEAT = 2'b11;

endpackage

// File: rtl/board_scan_mux.sv
// ---------------------------------------------------------------------------
// board_scan_mux
// Column-scanned LED matrix driver for the battleship board.
//   clk, clr     : system clock, async active-high reset
//   scan_tick    : advances the column counter (wraps COLS-1 -> 0)
//   mode         : selects what is shown (none / ships / attack / reveal)
//   ship_map     : ship layout, bit r*COLS+c is cell (r,c)
//   atk_map      : attacked cells, same indexing
//   m_col        : one-hot active-high column drive
//   m_line       : active-low line drive for the selected column
// ---------------------------------------------------------------------------
module board_scan_mux
   import batalha_naval_pkg::*;
#(
   parameter int ROWS = 7,
   parameter int COLS = 5
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 scan_tick,
   input  logic [1:0]           mode,
   input  logic [ROWS*COLS-1:0] ship_map,
   input  logic [ROWS*COLS-1:0] atk_map,
   output logic [COLS-1:0]      m_col,
   output logic [ROWS-1:0]      m_line
);

   localparam int CCW = (COLS > 1) ? $clog2(COLS) : 1;

   logic [CCW-1:0] r_col_cnt;
   logic           r_blink;

   // r_blink toggles once per full column sweep; misses flash at that rate.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_col_cnt <= '0;
         r_blink   <= 1'b0;
      end else if (scan_tick) begin
         if (r_col_cnt == CCW'(COLS - 1)) begin
            r_col_cnt <= '0;
            r_blink   <= ~r_blink;
         end else begin
            r_col_cnt <= r_col_cnt + CCW'(1);
         end
      end
   end

   logic [ROWS-1:0] w_ship_col;
   logic [ROWS-1:0] w_atk_col;
   logic [ROWS-1:0] w_lit;

   always_comb begin
      m_col      = '0;
      w_ship_col = '0;
      w_atk_col  = '0;
      for (int c = 0; c < COLS; c++) begin
         if (r_col_cnt == CCW'(c)) begin
            m_col[c] = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
               w_ship_col[r] = ship_map[r*COLS + c];
               w_atk_col[r]  = atk_map[r*COLS + c];
            end
         end
      end
   end

   always_comb begin
      w_lit = '0;
      case (mode)
         MODE_PLACE:  w_lit = w_ship_col;
         MODE_ATTACK: w_lit = (w_atk_col & w_ship_col)
                            | (w_atk_col & ~w_ship_col & {ROWS{r_blink}});
         MODE_REVEAL: w_lit = w_ship_col | w_atk_col;
         default:     w_lit = '0;
      endcase
   end

   assign m_line = ~w_lit;

endmodule

// File: rtl/batalha_naval_board.sv
// ---------------------------------------------------------------------------
// batalha_naval_board
// Battleship game board: holds the ship layout and attack map, judges shots,
// counts hits/shots and drives a column-scanned LED matrix.
//   clk, clr        : system clock, async active-high reset
//   mode            : 00 idle, 01 place, 10 attack, 11 reveal
//   load_map        : pulse, captures ship_map (mode 01) and starts a game
//   ship_map        : ship layout, bit r*COLS+c is cell (r,c)
//   fire            : pulse, attack at (row_sel, col_sel) (mode 10)
//   scan_tick       : display column-advance strobe
//   m_col, m_line   : matrix drive (one-hot high columns, active-low lines)
//   rgb_output      : last result 00 none, 01 miss, 10 hit, 11 repeat/invalid
//   hits, shots     : distinct hit cells, accepted shots
//   game_over       : high while in OVER
//
// state | meaning
// IDLE  | no game loaded (or loaded map had no ships)
// ARMED | game running, waiting for a shot
// CHECK | judging the latched shot coordinates
// OVER  | all ships sunk or shot budget spent
// ---------------------------------------------------------------------------
module batalha_naval_board
   import batalha_naval_pkg::*;
#(
   parameter int ROWS      = 7,
   parameter int COLS      = 5,
   parameter int MAX_SHOTS = 35
) (
   input  logic                              clk,
   input  logic                              clr,
   input  logic [1:0]                        mode,
   input  logic                              load_map,
   input  logic [ROWS*COLS-1:0]              ship_map,
   input  logic                              fire,
   input  logic [$clog2(ROWS)-1:0]           row_sel,
   input  logic [$clog2(COLS)-1:0]           col_sel,
   input  logic                              scan_tick,
   output logic [COLS-1:0]                   m_col,
   output logic [ROWS-1:0]                   m_line,
   output logic [1:0]                        rgb_output,
   output logic [$clog2(ROWS*COLS+1)-1:0]    hits,
   output logic [$clog2(MAX_SHOTS+1)-1:0]    shots,
   output logic                              game_over
);

   localparam int NC  = ROWS * COLS;
   localparam int RSW = $clog2(ROWS);
   localparam int CSW = $clog2(COLS);
   localparam int HW  = $clog2(NC + 1);
   localparam int SW  = $clog2(MAX_SHOTS + 1);
   localparam int IW  = (NC > 1) ? $clog2(NC) : 1;

   function automatic logic [HW-1:0] popcount(input logic [NC-1:0] v);
      logic [HW-1:0] s;
      s = '0;
      for (int i = 0; i < NC; i++) begin
         s = s + HW'(v[i]);
      end
      return s;
   endfunction

   state_t          r_state;
   logic [NC-1:0]   r_ship;
   logic [NC-1:0]   r_atk;
   logic [HW-1:0]   r_hits;
   logic [HW-1:0]   r_ships;
   logic [SW-1:0]   r_shots;
   logic [1:0]      r_rgb;
   logic [RSW-1:0]  r_row;
   logic [CSW-1:0]  r_col;

   logic            w_load;
   logic            w_fire;
   logic [HW-1:0]   w_ships_in;
   logic            w_valid;
   logic [IW-1:0]   w_idx;
   logic            w_is_ship;
   logic            w_is_repeat;
   logic [HW-1:0]   w_hits_nxt;
   logic [SW-1:0]   w_shots_nxt;
   logic            w_end;

   assign w_load     = load_map && (mode == MODE_PLACE);
   assign w_fire     = fire && (mode == MODE_ATTACK);
   assign w_ships_in = popcount(ship_map);

   // Coordinates are latched at the fire edge and judged one edge later, so
   // the result lands on the second edge after fire.
   assign w_valid     = (int'(r_row) < ROWS) && (int'(r_col) < COLS);
   assign w_idx       = IW'(int'(r_row) * COLS + int'(r_col));
   assign w_is_ship   = w_valid && r_ship[w_idx];
   assign w_is_repeat = w_valid && r_atk[w_idx];

   // Saturating increments; distinct cells bound hits, OVER bounds shots.
   assign w_hits_nxt  = !w_is_ship ? r_hits :
                        (r_hits == HW'(NC)) ? r_hits : r_hits + HW'(1);
   assign w_shots_nxt = (r_shots == SW'(MAX_SHOTS)) ? r_shots : r_shots + SW'(1);

   assign w_end = ((r_ships != '0) && (w_hits_nxt == r_ships))
                || (w_shots_nxt == SW'(MAX_SHOTS));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= IDLE;
         r_ship  <= '0;
         r_atk   <= '0;
         r_hits  <= '0;
         r_ships <= '0;
         r_shots <= '0;
         r_rgb   <= RGB_NONE;
         r_row   <= '0;
         r_col   <= '0;
      end else if (w_load) begin
         // A load restarts the game from any state and outranks a fire.
         r_ship  <= ship_map;
         r_atk   <= '0;
         r_hits  <= '0;
         r_shots <= '0;
         r_ships <= w_ships_in;
         r_state <= (w_ships_in != '0) ? ARMED : IDLE;
      end else begin
         case (r_state)
            ARMED: begin
               if (w_fire) begin
                  r_row   <= row_sel;
                  r_col   <= col_sel;
                  r_state <= CHECK;
               end
            end
            CHECK: begin
               if (!w_valid || w_is_repeat) begin
                  r_rgb   <= RGB_REPEAT;
                  r_state <= ARMED;
               end else begin
                  r_atk[w_idx] <= 1'b1;
                  r_shots      <= w_shots_nxt;
                  r_hits       <= w_hits_nxt;
                  r_rgb        <= w_is_ship ? RGB_HIT : RGB_MISS;
                  r_state      <= w_end ? OVER : ARMED;
               end
            end
            default: r_state <= r_state;
         endcase
      end
   end

   assign rgb_output = r_rgb;
   assign hits       = r_hits;
   assign shots      = r_shots;
   assign game_over  = (r_state == OVER);

   board_scan_mux #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_scan (
      .clk       (clk),
      .clr       (clr),
      .scan_tick (scan_tick),
      .mode      (mode),
      .ship_map  (r_ship),
      .atk_map   (r_atk),
      .m_col     (m_col),
      .m_line    (m_line)
   );

endmodule

// File: tb/tb_batalha_naval_board.sv
module tb_batalha_naval_board;
   import batalha_naval_pkg::*;

   logic        clk = 1'b0;
   logic        clr;
   logic [1:0]  mode;
   logic        load_map;
   logic [34:0] ship_map;
   logic        fire;
   logic [2:0]  row_sel;
   logic [2:0]  col_sel;
   logic        scan_tick;

   logic [4:0]  m_col,  m_col3;
   logic [6:0]  m_line, m_line3;
   logic [1:0]  rgb,    rgb3;
   logic [5:0]  hits,   hits3;
   logic [5:0]  shots;
   logic [1:0]  shots3;
   logic        go,     go3;

   batalha_naval_board dut (
      .clk(clk), .clr(clr), .mode(mode), .load_map(load_map), .ship_map(ship_map),
      .fire(fire), .row_sel(row_sel), .col_sel(col_sel), .scan_tick(scan_tick),
      .m_col(m_col), .m_line(m_line), .rgb_output(rgb), .hits(hits),
      .shots(shots), .game_over(go)
   );

   batalha_naval_board #(.ROWS(7), .COLS(5), .MAX_SHOTS(3)) dut3 (
      .clk(clk), .clr(clr), .mode(mode), .load_map(load_map), .ship_map(ship_map),
      .fire(fire), .row_sel(row_sel), .col_sel(col_sel), .scan_tick(scan_tick),
      .m_col(m_col3), .m_line(m_line3), .rgb_output(rgb3), .hits(hits3),
      .shots(shots3), .game_over(go3)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int         row;
      int         col;
      logic [1:0] rgb;
      int         hits;
      int         shots;
      logic       over;
   } shot_t;

   shot_t sb[$];

   int   scan_pos = 0;
   logic blink    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      scan_pos = 0;
      blink    = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      scan_tick = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0;
      if (scan_pos == 4) begin
         scan_pos = 0;
         blink    = ~blink;
      end else begin
         scan_pos++;
      end
   endtask

   task automatic tick_to(input int col);
      for (int k = 0; k < 5 && scan_pos != col; k++) tick();
   endtask

   task automatic load(input logic [34:0] map);
      @(negedge clk);
      mode     = MODE_PLACE;
      ship_map = map;
      load_map = 1'b1;
      @(negedge clk);
      load_map = 1'b0;
   endtask

   // Drive one shot, queue its expectation, compare two edges later.
   task automatic do_shot(input shot_t s, input bit on3);
      shot_t e;
      @(negedge clk);
      mode    = MODE_ATTACK;
      row_sel = s.row[2:0];
      col_sel = s.col[2:0];
      fire    = 1'b1;
      sb.push_back(s);
      @(negedge clk);
      fire = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      if (on3) begin
         check("rgb3",   rgb3,   e.rgb);
         check("hits3",  hits3,  e.hits);
         check("shots3", shots3, e.shots);
         check("over3",  go3,    e.over);
      end else begin
         check("rgb",   rgb,   e.rgb);
         check("hits",  hits,  e.hits);
         check("shots", shots, e.shots);
         check("over",  go,    e.over);
      end
   endtask

   shot_t vec[7];
   shot_t mx[4];

   initial begin
      clr = 1'b1; mode = MODE_IDLE; load_map = 1'b0; ship_map = '0;
      fire = 1'b0; row_sel = '0; col_sel = '0; scan_tick = 1'b0;

      // two-ship map: (0,0) and (6,4)
      vec[0] = '{7, 0, RGB_REPEAT, 0, 0, 1'b0};
      vec[1] = '{3, 2, RGB_MISS,   0, 1, 1'b0};
      vec[2] = '{3, 2, RGB_REPEAT, 0, 1, 1'b0};
      vec[3] = '{0, 5, RGB_REPEAT, 0, 1, 1'b0};
      vec[4] = '{0, 0, RGB_HIT,    1, 2, 1'b0};
      vec[5] = '{0, 0, RGB_REPEAT, 1, 2, 1'b0};
      vec[6] = '{6, 4, RGB_HIT,    2, 3, 1'b1};

      // MAX_SHOTS=3 instance, ship at (0,0) only
      mx[0] = '{1, 0, RGB_MISS, 0, 1, 1'b0};
      mx[1] = '{1, 1, RGB_MISS, 0, 2, 1'b0};
      mx[2] = '{1, 2, RGB_MISS, 0, 3, 1'b1};
      mx[3] = '{1, 3, RGB_MISS, 0, 3, 1'b1};

      // reset values
      #2;
      check("rst_m_col",  m_col,  5'b00001);
      check("rst_m_line", m_line, 7'h7f);
      check("rst_rgb",    rgb,    2'b00);
      check("rst_hits",   hits,   0);
      check("rst_shots",  shots,  0);
      check("rst_over",   go,     1'b0);
      @(negedge clk);
      clr = 1'b0;

      // fire in IDLE is ignored
      do_shot('{0, 0, RGB_NONE, 0, 0, 1'b0}, 1'b0);

      // single ship at (0,0)
      load(35'h1);
      check("armed_state", dut.r_state, ARMED);
      check("place_m_col", m_col, 5'b00001);
      check("place_line",  m_line, 7'b1111110);

      // hit at (0,0): nothing after one edge, result after the second
      @(negedge clk);
      mode = MODE_ATTACK; row_sel = 3'd0; col_sel = 3'd0; fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
      check("lat1_shots", shots, 0);
      check("lat1_rgb",   rgb,   RGB_NONE);
      @(negedge clk);
      check("lat2_rgb",   rgb,   RGB_HIT);
      check("lat2_hits",  hits,  1);
      check("lat2_shots", shots, 1);
      check("lat2_over",  go,    1'b1);

      // fire in OVER ignored
      do_shot('{1, 1, RGB_HIT, 1, 1, 1'b1}, 1'b0);

      // two-ship game driven from the table
      load(35'h4_0000_0001);
      check("reload_over", go, 1'b0);
      for (int i = 0; i < 7; i++) begin
         do_shot(vec[i], 1'b0);
         if (i == 1) begin
            tick_to(2);
            #1 check("atk_miss_blink", m_line, blink ? 7'b1110111 : 7'b1111111);
            mode = MODE_REVEAL;
            #1 check("reveal_col2", m_line, 7'b1110111);
            mode = MODE_ATTACK;
            for (int k = 0; k < 5; k++) tick();
            #1 check("atk_miss_blink2", m_line, blink ? 7'b1110111 : 7'b1111111);
            mode = MODE_PLACE;
            #1 check("place_col2", m_line, 7'h7f);
            tick_to(0);
            #1 check("place_col0", m_line, 7'b1111110);
            mode = MODE_IDLE;
            #1 check("idle_col0", m_line, 7'h7f);
         end
      end
      tick_to(0);
      mode = MODE_ATTACK;
      #1 check("atk_hit_col0", m_line, 7'b1111110);

      // shot budget exhaustion on the MAX_SHOTS=3 instance
      do_reset();
      load(35'h1);
      for (int i = 0; i < 4; i++) do_shot(mx[i], 1'b1);

      // column scan sequence
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("scan_m_col", m_col, 5'b00001 << scan_pos);
      end

      // reset while in CHECK
      load(35'h1);
      tick();
      tick();
      @(negedge clk);
      mode = MODE_ATTACK; row_sel = 3'd0; col_sel = 3'd0; fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
      check("pre_clr_state", dut.r_state, CHECK);
      clr = 1'b1;
      #1;
      check("clr_state",  dut.r_state, IDLE);
      check("clr_m_col",  m_col,  5'b00001);
      check("clr_m_line", m_line, 7'h7f);
      check("clr_rgb",    rgb,    2'b00);
      check("clr_hits",   hits,   0);
      check("clr_shots",  shots,  0);
      check("clr_over",   go,     1'b0);
      @(negedge clk);
      clr = 1'b0;
      scan_pos = 0;
      blink    = 1'b0;
      @(negedge clk);
      check("post_clr_rgb",   rgb,   2'b00);
      check("post_clr_shots", shots, 0);
      check("post_clr_hits",  hits,  0);
      check("post_clr_state", dut.r_state, IDLE);
      do_shot('{0, 0, RGB_NONE, 0, 0, 1'b0}, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
